tia_write_strobe_queue: RTL

Parametrised successor to the TIA write-address decoder. It samples the 6502-side bus (address, data, w_bar) on phi2 falling edges in the fast system clock domain and queues accepted writes in a DEPTH-entry FIFO. Each popped entry is presented with a one-hot register strobe under a valid/ready handshake. It sits between the CPU bus interface and the TIA register/object logic, so downstream consumers may stall without losing writes.

---
 rtl/tia_write_pkg.sv | 23 ++
 rtl/tia_write_strobe_queue_if.sv | 26 ++
 rtl/tia_write_fifo.sv | 47 ++++
 rtl/tia_write_strobe_queue.sv | 93 +++++++++
 4 files changed

// File: rtl/tia_write_pkg.sv
// Shared definitions for the TIA write path: register map and strobe decode.
package tia_write_pkg;

  localparam int unsigned NUM_TIA_WRITE_REGS = 45;
  localparam int unsigned MAX_DECODE_WIDTH   = 8;

  typedef enum logic [5:0] {
    VSYNC = 6'd0, VBLANK, WSYNC, RSYNC, NUSIZ0, NUSIZ1, COLUP0, COLUP1, COLUPF, COLUBK,
    CTRLPF, REFP0, REFP1, PF0, PF1, PF2, RESP0, RESP1, RESM0, RESM1, RESBL,
    AUDC0, AUDC1, AUDF0, AUDF1, AUDV0, AUDV1, GRP0, GRP1, ENAM0, ENAM1, ENABL,
    HMP0, HMP1, HMM0, HMM1, HMBL, VDELP0, VDELP1, VDELBL, RESMP0, RESMP1,
    HMOVE, HMCLR, CXCLR
  } tia_write_reg_e;

  // Callers truncate the result to their own register count.
  function automatic logic [2**MAX_DECODE_WIDTH-1:0] onehot_decode(
    input logic [MAX_DECODE_WIDTH-1:0] addr
  );
    onehot_decode       = '0;
    onehot_decode[addr] = 1'b1;
  endfunction

endpackage

// File: rtl/tia_write_strobe_queue_if.sv
// CPU bus sampling inputs and the strobe/handshake output side of the write queue.
interface tia_write_strobe_queue_if #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_REGS   = 45
);
  logic                  phi2;
  logic [ADDR_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] d;
  logic                  w_bar;
  logic                  out_ready;
  logic                  out_valid;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic [DATA_WIDTH-1:0] out_data;
  logic [NUM_REGS-1:0]   strobe;

  modport master (
    output phi2, a, d, w_bar, out_ready,
    input  out_valid, out_addr, out_data, strobe
  );

  modport slave (
    input  phi2, a, d, w_bar, out_ready,
    output out_valid, out_addr, out_data, strobe
  );
endinterface

// File: rtl/tia_write_fifo.sv
// Generic synchronous FIFO; head reads as zero while empty.
module tia_write_fifo #(
  parameter int unsigned WIDTH = 14,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_WIDTH   = $clog2(DEPTH),
  localparam int unsigned LEVEL_WIDTH = PTR_WIDTH + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic                   full,
  output logic                   empty,
  output logic [LEVEL_WIDTH-1:0] level,
  output logic [WIDTH-1:0]       head
);
  logic [WIDTH-1:0]       mem_q [DEPTH];
  logic [PTR_WIDTH-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LEVEL_WIDTH-1:0] level_q;
  logic                   do_push, do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LEVEL_WIDTH'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push & (~full | do_pop);
  assign level   = level_q;
  assign head    = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_WIDTH'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_WIDTH'(1);
      level_q <= level_q + LEVEL_WIDTH'(do_push) - LEVEL_WIDTH'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/tia_write_strobe_queue.sv
// Samples 6502 writes on phi2 falling edges and replays them as one-hot strobes.
module tia_write_strobe_queue
  import tia_write_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_REGS   = 45,
  parameter int unsigned DEPTH      = 4,
  localparam int unsigned LEVEL_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  tia_write_strobe_queue_if.slave bus,
  input  logic                   clear_flags,
  output logic [LEVEL_WIDTH-1:0] level,
  output logic                   overflow,
  output logic                   bad_addr
);
  localparam int unsigned ENTRY_WIDTH = ADDR_WIDTH + DATA_WIDTH;
  localparam logic [ADDR_WIDTH:0] NUM_REGS_EXT = (ADDR_WIDTH + 1)'(NUM_REGS);

  logic                  s1_q, s2_q, fall;
  logic [ADDR_WIDTH-1:0] hold_addr_q;
  logic [DATA_WIDTH-1:0] hold_data_q;
  logic                  hold_w_bar_q;
  logic                  wr_cycle, addr_ok, push, pop, full, empty;
  logic                  overflow_q, bad_addr_q;
  logic [ENTRY_WIDTH-1:0] head;
  logic [ADDR_WIDTH-1:0] head_addr;

  // Hold register tracks the bus while phi2 is high, freezing it at the falling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      hold_addr_q  <= '0;
      hold_data_q  <= '0;
      hold_w_bar_q <= 1'b0;
    end else begin
      s1_q <= bus.phi2;
      s2_q <= s1_q;
      if (s1_q) begin
        hold_addr_q  <= bus.a;
        hold_data_q  <= bus.d;
        hold_w_bar_q <= bus.w_bar;
      end
    end
  end

  assign fall     = s2_q & ~s1_q;
  assign wr_cycle = fall & ~hold_w_bar_q;
  assign addr_ok  = {1'b0, hold_addr_q} < NUM_REGS_EXT;
  assign push     = wr_cycle & addr_ok;
  assign pop      = ~empty & bus.out_ready;

  tia_write_fifo #(
    .WIDTH (ENTRY_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({hold_addr_q, hold_data_q}),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .head      (head)
  );

  assign head_addr     = head[ENTRY_WIDTH-1:DATA_WIDTH];
  assign bus.out_valid = ~empty;
  assign bus.out_addr  = head_addr;
  assign bus.out_data  = head[DATA_WIDTH-1:0];
  assign bus.strobe    = pop ? NUM_REGS'(onehot_decode(MAX_DECODE_WIDTH'(head_addr))) : '0;

  // Set events take priority over clear_flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q <= 1'b0;
      bad_addr_q <= 1'b0;
    end else begin
      if (push & full & ~pop) overflow_q <= 1'b1;
      else if (clear_flags)   overflow_q <= 1'b0;
      if (wr_cycle & ~addr_ok) bad_addr_q <= 1'b1;
      else if (clear_flags)    bad_addr_q <= 1'b0;
    end
  end

  assign overflow = overflow_q;
  assign bad_addr = bad_addr_q;

endmodule
